mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: `clk` is the single clock, `rst` is async active-high.
REQ-002 The block SHALL provide these ports (name, direction, width, meaning):
- clk  in  1  system clock
- rst  in  1  async active-high reset
- i_req  in  1  I-side block-fill request; held until i_done
- i_addr  in  16  I-side miss address
- d_req  in  1  D-side request; held until d_done
- d_wr  in  1  D-side type: 1 = single-word write-through, 0 = 8-word fill
- d_addr  in  16  D-side address
- d_wdata  in  16  D-side write data
- mem_data_in  in  16  memory read data
- mem_data_valid  in  1  memory read data valid, 4 cycles after issue
- mem_enable  out  1  memory access issue strobe
- mem_wr  out  1  memory write strobe
- mem_addr  out  16  memory address
- mem_data_out  out  16  memory write data
- i_grant, d_grant  out  1 each  owner of the memory port
- fill_valid  out  1  returned fill word valid, for the granted side's data array
- fill_addr  out  16  word address of the returned fill word
- fill_data  out  16  returned fill word, equal to mem_data_in
- i_done, d_done  out  1 each  1-cycle completion pulse

Function
REQ-003 The block SHALL implement the states IDLE, I_FILL, D_FILL and D_WRITE in a registered state machine.
REQ-004 IDLE: the block SHALL sample requests each cycle. A winner moves the FSM to I_FILL, D_FILL (d_wr=0) or D_WRITE (d_wr=1) on the next edge. The block SHALL latch base = addr & 16'hFFF0 for fills, and the address and data for writes.
REQ-005 Default arbitration SHALL be fixed priority, D over I, when both requests are asserted in the same IDLE cycle.
REQ-006 A grant SHALL be asserted for the whole non-IDLE state. The block SHALL not preempt a grant, and SHALL ignore request deassertion mid-transaction.
REQ-007 Fill issue: the block SHALL assert mem_enable=1 and mem_wr=0 on 8 consecutive cycles starting the first cycle in the FILL state. mem_addr SHALL be base + 2*issue_cnt, with the 3-bit issue_cnt running 0..7. mem_enable SHALL be 0 after 8 issues.
REQ-008 Fill return: each mem_data_valid in a FILL state SHALL produce fill_valid=1 in the same cycle. fill_addr SHALL be base + 2*ret_cnt and fill_data SHALL equal mem_data_in. ret_cnt (3 bits) SHALL then increment.
REQ-009 Fill completion: when mem_data_valid is high and ret_cnt=7, the block SHALL pulse the granted side's done in the same cycle, and the state SHALL become IDLE on the next edge.
REQ-010 D_WRITE SHALL last exactly one cycle: mem_enable=1, mem_wr=1, mem_addr equal to the latched address, mem_data_out equal to the latched data, d_done=1. The state SHALL then become IDLE.
REQ-011 Latency: with a request in IDLE cycle N, the grant SHALL be asserted at N+1 and issues SHALL occur N+1..N+8. Returns SHALL arrive N+5..N+12, with done at N+12. The earliest next grant SHALL be N+14.
REQ-012 The block SHALL ignore mem_data_valid in IDLE and D_WRITE.
REQ-013 Outside the conditions above, mem_enable, mem_wr, fill_valid, i_done and d_done SHALL be 0. mem_addr, mem_data_out and fill_addr SHALL be 16'h0000 in IDLE.
REQ-014 All address arithmetic SHALL be modulo 2^16 with no saturation, so a block at 16'hFFF0 issues up to 16'hFFFE.

Reset
REQ-015 rst SHALL asynchronously force IDLE, clear issue_cnt, ret_cnt, the latched address and data, and the round-robin pointer, and drive every output to 0.
REQ-016 Reset mid-transaction SHALL abandon the transaction with no done pulse. Returns still in flight after reset is released SHALL be ignored per REQ-012.

Configuration
REQ-017 Macro MEM_ARB_RR_EN:
- Defined: ties in IDLE SHALL be resolved round-robin. A last_served register (reset = D) SHALL be updated at each grant. A tie SHALL go to the side not last served, so the first tie after reset goes to I.
- Undefined: fixed D-over-I priority per REQ-005, with no last_served register.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- i_req=1, i_addr=16'h1234, memory returning word k as 16'hA000+k after 4 cycles -> mem_addr 16'h1230..16'h123E over 8 cycles, then fill_addr 16'h1230..16'h123E with data A000..A007, i_done at the 8th return, i_grant low the next cycle.
- d_req=1, d_wr=1, d_addr=16'h0042, d_wdata=16'hBEEF -> one cycle with mem_enable=1, mem_wr=1, mem_addr=16'h0042, mem_data_out=16'hBEEF, d_done=1.
- i_req and d_req (fill) rise together, macro undefined -> D served first, I granted 2 cycles after d_done; with MEM_ARB_RR_EN defined -> I served first.
- d_addr=16'hFFF8, fill -> issue addresses 16'hFFF0..16'hFFFE, no wrap past 16'hFFFE.
- rst pulsed after the 3rd return of a fill -> all outputs 0 immediately, no done, later stray mem_data_valid produces no fill_valid.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D memory port arbiter with 8-word block fill and write-through sequencing
//
// Purpose: grants the single memory port to the I side (block fills) or the
// D side (block fills or single-word write-through), sequences the 8 fill
// issues and the 8 returned words, and pulses the owner's done on completion.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   i_req, i_addr                 I-side fill request (held until i_done) and miss address
//   d_req, d_wr, d_addr, d_wdata  D-side request (held until d_done), 1=write/0=fill, address, write data
//   mem_data_in, mem_data_valid   memory read return, valid 4 cycles after issue
//   mem_enable, mem_wr            memory issue strobe and write strobe
//   mem_addr, mem_data_out        memory address and write data
//   i_grant, d_grant              current owner of the memory port
//   fill_valid, fill_addr, fill_data  returned fill word for the owner's data array
//   i_done, d_done                1-cycle completion pulses
//
// Configuration: define MEM_ARB_RR_EN to resolve simultaneous requests
// round-robin; otherwise D always wins a tie.

module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  input  logic [15:0] mem_data_in,
  input  logic        mem_data_valid,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_out,
  output logic        i_grant,
  output logic        d_grant,
  output logic        fill_valid,
  output logic [15:0] fill_addr,
  output logic [15:0] fill_data,
  output logic        i_done,
  output logic        d_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_FILL  = 2'd1,
    D_FILL  = 2'd2,
    D_WRITE = 2'd3
  } state_t;

  state_t      state, next_state;
  logic [15:0] lat_addr;    // fill base (block aligned) or write address
  logic [15:0] lat_data;    // write-through data
  logic [2:0]  issue_cnt;
  logic [2:0]  ret_cnt;
  logic        issue_busy;  // high while fill issues remain; issue_cnt wraps after 7
  logic        pick_d, pick_i;

`ifdef MEM_ARB_RR_EN
  // last_d = 1 when D was granted most recently; a tie goes to the other side.
  logic last_d;

  always_comb begin
    pick_d = d_req & (~i_req | ~last_d);
    pick_i = i_req & ~pick_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d <= 1'b1;
    end else if (state == IDLE && (pick_d || pick_i)) begin
      last_d <= pick_d;
    end
  end
`else
  always_comb begin
    pick_d = d_req;
    pick_i = i_req & ~d_req;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state   = state;
    mem_enable   = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = 16'h0000;
    mem_data_out = 16'h0000;
    i_grant      = 1'b0;
    d_grant      = 1'b0;
    fill_valid   = 1'b0;
    fill_addr    = 16'h0000;
    fill_data    = 16'h0000;
    i_done       = 1'b0;
    d_done       = 1'b0;
    case (state)
      IDLE: begin
        if (pick_d) begin
          next_state = d_wr ? D_WRITE : D_FILL;
        end else if (pick_i) begin
          next_state = I_FILL;
        end
      end
      I_FILL, D_FILL: begin
        i_grant    = (state == I_FILL);
        d_grant    = (state == D_FILL);
        mem_enable = issue_busy;
        if (issue_busy) begin
          mem_addr = lat_addr + {12'd0, issue_cnt, 1'b0};
        end
        // Returns are accepted only while a fill owns the port.
        if (mem_data_valid) begin
          fill_valid = 1'b1;
          fill_addr  = lat_addr + {12'd0, ret_cnt, 1'b0};
          fill_data  = mem_data_in;
          if (ret_cnt == 3'd7) begin
            i_done     = (state == I_FILL);
            d_done     = (state == D_FILL);
            next_state = IDLE;
          end
        end
      end
      D_WRITE: begin
        d_grant      = 1'b1;
        mem_enable   = 1'b1;
        mem_wr       = 1'b1;
        mem_addr     = lat_addr;
        mem_data_out = lat_data;
        d_done       = 1'b1;
        next_state   = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_addr   <= 16'h0000;
      lat_data   <= 16'h0000;
      issue_cnt  <= 3'd0;
      ret_cnt    <= 3'd0;
      issue_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          issue_cnt <= 3'd0;
          ret_cnt   <= 3'd0;
          if (pick_d) begin
            lat_addr   <= d_wr ? d_addr : (d_addr & 16'hFFF0);
            issue_busy <= ~d_wr;
            if (d_wr) begin
              lat_data <= d_wdata;
            end
          end else if (pick_i) begin
            lat_addr   <= i_addr & 16'hFFF0;
            issue_busy <= 1'b1;
          end
        end
        I_FILL, D_FILL: begin
          if (issue_busy) begin
            issue_cnt <= issue_cnt + 3'd1;
            if (issue_cnt == 3'd7) begin
              issue_busy <= 1'b0;
            end
          end
          if (mem_data_valid) begin
            ret_cnt <= ret_cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with randomized transactions

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic [15:0] mem_data_in;
  logic        mem_data_valid;
  logic        mem_enable, mem_wr;
  logic [15:0] mem_addr, mem_data_out;
  logic        i_grant, d_grant;
  logic        fill_valid;
  logic [15:0] fill_addr, fill_data;
  logic        i_done, d_done;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_data_in(mem_data_in), .mem_data_valid(mem_data_valid),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
    .i_grant(i_grant), .d_grant(d_grant),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data),
    .i_done(i_done), .d_done(d_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: a read issued in cycle t returns salt + word index in cycle t+4.
  logic [15:0] salt = 16'h0000;
  logic [3:0]  pv = 4'd0;
  logic [15:0] pd [4] = '{default: 16'h0000};
  always @(posedge clk) begin
    pv    <= {pv[2:0], mem_enable & ~mem_wr};
    pd[0] <= salt + {13'd0, mem_addr[3:1]};
    pd[1] <= pd[0];
    pd[2] <= pd[1];
    pd[3] <= pd[2];
  end
  assign mem_data_valid = pv[3];
  assign mem_data_in    = pd[3];

  typedef struct { bit side_d; int cyc; } grant_t;
  typedef struct { bit wr; logic [15:0] addr; logic [15:0] data; int cyc; bit side_d; } issue_t;
  typedef struct { logic [15:0] addr; logic [15:0] data; int cyc; bit last; bit side_d; } ret_t;

  grant_t q_grant[$];
  issue_t q_issue[$];
  ret_t   q_ret[$];

  int checks = 0;
  int errors = 0;
  int fv_count = 0;
  bit last_d_m = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one granted transaction starting at cycle gcyc.
  task automatic model_txn(input bit side_d, input bit wr, input logic [15:0] addr,
                           input logic [15:0] wd, input int gcyc, output int end_cyc);
    logic [15:0] base;
    q_grant.push_back('{side_d: side_d, cyc: gcyc});
    if (side_d && wr) begin
      q_issue.push_back('{wr: 1'b1, addr: addr, data: wd, cyc: gcyc, side_d: 1'b1});
      end_cyc = gcyc;
    end else begin
      base = addr & 16'hFFF0;
      for (int k = 0; k < 8; k++) begin
        q_issue.push_back('{wr: 1'b0, addr: base + 16'(2 * k), data: 16'h0, cyc: gcyc + k, side_d: side_d});
        q_ret.push_back('{addr: base + 16'(2 * k), data: salt + 16'(k), cyc: gcyc + 4 + k,
                          last: (k == 7), side_d: side_d});
      end
      end_cyc = gcyc + 11;
    end
  endtask

  task automatic run(input bit do_i, input bit do_d, input bit wr,
                     input logic [15:0] ia, input logic [15:0] da, input logic [15:0] wd);
    bit first_d;
    int e1, e2;
    @(negedge clk); #2;
    if (do_i && do_d) begin
`ifdef MEM_ARB_RR_EN
      first_d = ~last_d_m;
`else
      first_d = 1'b1;
`endif
    end else begin
      first_d = do_d;
    end
    if (first_d) begin
      model_txn(1'b1, wr, da, wd, cyc + 1, e1);
      last_d_m = 1'b1;
      if (do_i) begin
        model_txn(1'b0, 1'b0, ia, 16'h0, e1 + 2, e2);
        last_d_m = 1'b0;
      end
    end else begin
      model_txn(1'b0, 1'b0, ia, 16'h0, cyc + 1, e1);
      last_d_m = 1'b0;
      if (do_d) begin
        model_txn(1'b1, wr, da, wd, e1 + 2, e2);
        last_d_m = 1'b1;
      end
    end
    i_addr = ia; d_addr = da; d_wdata = wd; d_wr = wr;
    i_req = do_i; d_req = do_d;
    for (int t = 0; t < 80 && (i_req || d_req); t++) begin
      @(negedge clk); #2;
      if (i_done) i_req = 1'b0;
      if (d_done) d_req = 1'b0;
    end
    chk("txn_completed", {i_req, d_req}, 2'b00);
    i_req = 1'b0; d_req = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  task automatic reset_mid();
    int nret, gc, e1, fv0;
    salt = 16'h7700;
    @(negedge clk); #2;
    gc = cyc + 1;
    model_txn(1'b0, 1'b0, 16'h5678, 16'h0, gc, e1);
    last_d_m = 1'b0;
    i_addr = 16'h5678; i_req = 1'b1;
    nret = 0;
    for (int t = 0; t < 40 && nret < 3; t++) begin
      @(negedge clk); #2;
      if (fill_valid) nret++;
    end
    chk("reset_third_return_seen", nret, 3);
    rst = 1'b1; i_req = 1'b0;
    q_grant.delete(); q_issue.delete(); q_ret.delete();
    last_d_m = 1'b1;
    #1;
    chk("reset_ctrl_zero", {i_grant, d_grant, mem_enable, mem_wr, fill_valid, i_done, d_done}, 0);
    chk("reset_data_zero", {mem_addr, mem_data_out, fill_addr, fill_data}, 0);
    @(negedge clk); #2;
    rst = 1'b0;
    fv0 = fv_count;
    repeat (10) @(negedge clk);
    chk("stray_fill_valid", fv_count - fv0, 0);
  endtask

  // Monitor: pops and compares whenever the DUT presents an event.
  logic [1:0] prev_g = 2'b00;
  grant_t mg;
  issue_t mi;
  ret_t   mr;
  always begin
    @(negedge clk); #1;
    if (fill_valid) fv_count++;
    if (!rst) begin
      chk("grant_onehot", i_grant & d_grant, 0);
      if ({d_grant, i_grant} != 2'b00 && prev_g == 2'b00) begin
        if (q_grant.size() == 0) chk("grant_expected", 1, 0);
        else begin
          mg = q_grant.pop_front();
          chk("grant_side", d_grant, mg.side_d);
          chk("grant_cycle", cyc, mg.cyc);
        end
      end
      if (mem_enable) begin
        if (q_issue.size() == 0) chk("issue_expected", 1, 0);
        else begin
          mi = q_issue.pop_front();
          chk("issue_wr", mem_wr, mi.wr);
          chk("issue_addr", mem_addr, mi.addr);
          chk("issue_cycle", cyc, mi.cyc);
          chk("issue_owner", d_grant, mi.side_d);
          if (mi.wr) begin
            chk("write_data", mem_data_out, mi.data);
            chk("write_done", {i_done, d_done}, 2'b01);
          end
        end
      end
      if (fill_valid) begin
        if (q_ret.size() == 0) chk("return_expected", 1, 0);
        else begin
          mr = q_ret.pop_front();
          chk("fill_addr", fill_addr, mr.addr);
          chk("fill_data", fill_data, mr.data);
          chk("fill_cycle", cyc, mr.cyc);
          chk("fill_owner", d_grant, mr.side_d);
          chk("fill_done", {i_done, d_done}, {mr.last & ~mr.side_d, mr.last & mr.side_d});
        end
      end else if (!(mem_enable && mem_wr)) begin
        chk("no_stray_done", {i_done, d_done}, 2'b00);
      end
      if ({d_grant, i_grant} == 2'b00) begin
        chk("idle_outputs_zero",
            {mem_enable, mem_wr, fill_valid, i_done, d_done, mem_addr, mem_data_out, fill_addr}, 0);
      end
    end
    prev_g = {d_grant, i_grant};
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ri, rd;
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    i_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("por_ctrl_zero", {i_grant, d_grant, mem_enable, mem_wr, fill_valid, i_done, d_done}, 0);
    chk("por_data_zero", {mem_addr, mem_data_out, fill_addr, fill_data}, 0);
    #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    salt = 16'hA000;
    run(1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000, 16'h0000);
    run(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0042, 16'hBEEF);
    salt = 16'h3C00;
    run(1'b1, 1'b1, 1'b0, 16'h2468, 16'h9ABC, 16'h0000);
    run(1'b0, 1'b1, 1'b0, 16'h0000, 16'hFFF8, 16'h0000);
    reset_mid();
    run(1'b1, 1'b1, 1'b0, 16'h4000, 16'h8000, 16'h0000);
    run(1'b1, 1'b1, 1'b1, 16'h1111, 16'h2222, 16'h3333);

    for (int n = 0; n < 30; n++) begin
      salt = 16'($urandom);
      ri = 1'($urandom);
      rd = 1'($urandom);
      if (!ri && !rd) rd = 1'b1;
      run(ri, rd, 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    end

    repeat (4) @(negedge clk);
    chk("queues_drained", {16'(q_grant.size()), 16'(q_issue.size()), 16'(q_ret.size())}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
